// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b memory-side types: bus words, byte selects, 128-bit lines and
// the line responder state encoding.
package lc3b_types;

  localparam int LINE_WORDS = 8;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_sel;
  typedef logic [127:0] lc3b_line;
  typedef logic [2:0]   lc3b_widx;
  typedef logic [11:0]  lc3b_tag;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mem_resp_state_t;

  function automatic lc3b_word line_word(input lc3b_line line, input lc3b_widx w);
    return line[{w, 4'h0} +: 16];
  endfunction

endpackage

// File: rtl/mem_line_responder_merge.sv
// Byte-lane merge of one CPU word into a 128-bit line; purely combinational.
// Shared with the cache so both merge writes identically.
module line_byte_merge
  import lc3b_types::*;
(
  input  logic [127:0] line_in,
  input  logic [2:0]   widx,
  input  logic [1:0]   byte_en,
  input  logic [15:0]  wdata,
  output logic [127:0] line_out
);

  always_comb begin
    line_out = line_in;
    if (byte_en[0]) line_out[{widx, 4'h0} +: 8] = wdata[7:0];
    if (byte_en[1]) line_out[{widx, 4'h8} +: 8] = wdata[15:8];
  end

endmodule

// File: rtl/mem_line_responder.sv
// CPU word/byte requests over a 128-bit line memory: fetch, merge, write back.
// Optional one-line buffer (write-through) when MEM_LINE_BUF_EN is defined.
module mem_line_responder
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  mem_resp_state_t state, state_nxt;
  lc3b_line        line_q, line_nxt;
  lc3b_line        merge_src, merged;
  lc3b_widx        widx;
  lc3b_tag         tag;
  logic            do_wr;
  logic            unused_addr_bit;

  assign widx            = mem_address[3:1];
  assign tag             = mem_address[15:4];
  assign unused_addr_bit = mem_address[0];
  // A write with no lanes enabled behaves like a read: fetch and respond.
  assign do_wr           = mem_write && (mem_byte_enable != 2'b00);

`ifdef MEM_LINE_BUF_EN
  logic     buf_vld;
  lc3b_tag  buf_tag;
  lc3b_line buf_data;
  logic     buf_hit;

  assign buf_hit   = buf_vld && (buf_tag == tag);
  assign merge_src = (state == IDLE) ? buf_data : pmem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if (pmem_resp && state == FETCH) begin
      buf_vld  <= 1'b1;
      buf_tag  <= tag;
      buf_data <= pmem_rdata;
    end else if (pmem_resp && state == WRITE) begin
      buf_vld  <= 1'b1;
      buf_tag  <= tag;
      buf_data <= line_q;
    end
  end
`else
  assign merge_src = pmem_rdata;
`endif

  line_byte_merge u_merge (
    .line_in  (merge_src),
    .widx     (widx),
    .byte_en  (mem_byte_enable),
    .wdata    (mem_wdata),
    .line_out (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      line_q <= '0;
    end else begin
      state  <= state_nxt;
      line_q <= line_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    line_nxt  = line_q;
    unique case (state)
      IDLE: begin
        if (mem_write || mem_read) begin
          state_nxt = FETCH;
`ifdef MEM_LINE_BUF_EN
          if (buf_hit) begin
            if (do_wr) begin
              state_nxt = WRITE;
              line_nxt  = merged;
            end else begin
              state_nxt = RESP;
              line_nxt  = buf_data;
            end
          end
`endif
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          if (do_wr) begin
            state_nxt = WRITE;
            line_nxt  = merged;
          end else begin
            state_nxt = RESP;
            line_nxt  = pmem_rdata;
          end
        end
      end
      WRITE: begin
        if (pmem_resp) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so reset drops them without a clock.
  assign pmem_read    = (state == FETCH);
  assign pmem_write   = (state == WRITE);
  assign mem_resp     = (state == RESP);
  assign pmem_address = {mem_address[15:4], 4'h0};
  assign pmem_wdata   = line_q;
  assign mem_rdata    = line_word(line_q, widx);

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboarded random + directed bench for mem_line_responder with a
// behavioural line memory and a word-addressed reference memory.
module tb_mem_line_responder;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
  logic         mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [127:0] pmem_wdata, pmem_rdata;

  mem_line_responder dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Physical memory model
  logic [127:0] pmem_arr [0:4095];
  int pm_wait = -1;
  int force_delay = -1;
  int rd_txn = 0;
  int wr_txn = 0;
  int last_presp_cyc = -100;

  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if (reset || !(pmem_read || pmem_write)) begin
        pm_wait = -1;
      end else begin
        if (pm_wait < 0) pm_wait = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        if (pm_wait == 0) begin
          pmem_resp      = 1'b1;
          pm_wait        = -1;
          last_presp_cyc = cyc;
          if (pmem_read) begin
            pmem_rdata = pmem_arr[pmem_address[15:4]];
            rd_txn++;
          end else begin
            pmem_arr[pmem_address[15:4]] = pmem_wdata;
            wr_txn++;
          end
        end else begin
          pm_wait--;
        end
      end
    end
  end

  // Reference model and scoreboard
  logic [15:0] ref_words [0:32767];
  logic [15:0] exp_q [$];
  logic [15:0] exp_addr = '0;
  bit          resp_seen = 0;
  int          last_resp_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pmem_resp && (pmem_read || pmem_write)) chk("pmem_address", pmem_address, exp_addr);
      if (mem_resp) begin
        resp_seen     = 1;
        last_resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_resp", 1, 0);
        end else begin
          chk("mem_rdata", mem_rdata, exp_q.pop_front());
`ifndef MEM_LINE_BUF_EN
          chk("resp_latency", cyc, last_presp_cyc + 1);
`endif
        end
      end
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [1:0] be,
                     input logic [15:0] addr, input logic [15:0] wd, output int rel);
    int idx;
    int rd0;
    int wr0;
    int c0;
    int t;
    logic [15:0] cur;
    idx = int'(addr >> 1);
    if (wr) begin
      cur = ref_words[idx];
      if (be[0]) cur[7:0]  = wd[7:0];
      if (be[1]) cur[15:8] = wd[15:8];
      ref_words[idx] = cur;
    end
    exp_q.push_back(ref_words[idx]);
    exp_addr = {addr[15:4], 4'h0};
    rd0 = rd_txn;
    wr0 = wr_txn;
    @(posedge clk);
    #1;
    c0 = cyc;
    resp_seen = 0;
    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    mem_address = addr; mem_wdata = wd;
    t = 0;
    while (!resp_seen && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    rel = last_resp_cyc - c0;
    if (!resp_seen) begin
      chk("resp_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    #1;
    chk("resp_single_pulse", mem_resp, 0);
`ifndef MEM_LINE_BUF_EN
    chk("fetch_count", rd_txn - rd0, 1);
    chk("writeback_count", wr_txn - wr0, (wr && be != 2'b00) ? 1 : 0);
`endif
  endtask

  initial begin
    int rel;
    int t;
    logic [127:0] ln;
    reset = 1'b1;
    mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    for (int l = 0; l < 4096; l++) begin
      ln = {$urandom, $urandom, $urandom, $urandom};
      if (l == 1) ln = {8{16'h1234}};
      if (l == 3) ln[63:48] = 16'hBEEF;
      pmem_arr[l] = ln;
      for (int w = 0; w < 8; w++) ref_words[l*8 + w] = ln[16*w +: 16];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    reset = 1'b0;

    // Directed cases
    force_delay = 2;
    req(1, 0, 2'b11, 16'h0036, 16'h0000, rel);
    chk("read_resp_cycle", rel, 4);
    force_delay = 1;
    req(0, 1, 2'b01, 16'h0010, 16'h00AA, rel);
    req(0, 1, 2'b10, 16'h001E, 16'h5500, rel);
    req(0, 1, 2'b00, 16'h0020, 16'hFFFF, rel);
    chk("line1_after_byte_writes", pmem_arr[1],
        {16'h5534, {6{16'h1234}}, 16'h12AA});

    // Reset while the writeback is outstanding
    force_delay = 6;
    exp_addr = 16'h0050;
    @(posedge clk);
    #1;
    mem_write = 1; mem_byte_enable = 2'b11; mem_address = 16'h0050; mem_wdata = 16'hDEAD;
    t = 0;
    while (!pmem_write && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("reached_write", pmem_write, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_drop_pmem_write", pmem_write, 0);
    chk("async_mem_resp_low", mem_resp, 0);
    @(posedge clk);
    #1;
    mem_write = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_pmem_wdata", pmem_wdata, 0);
    chk("rst2_mem_rdata", mem_rdata, 0);
    reset = 1'b0;
    force_delay = -1;
    req(1, 0, 2'b00, 16'h0050, 16'h0000, rel);

`ifdef MEM_LINE_BUF_EN
    begin
      int f0;
      req(1, 0, 2'b11, 16'h0040, 16'h0000, rel);
      f0 = rd_txn;
      req(1, 0, 2'b11, 16'h0042, 16'h0000, rel);
      chk("buf_hit_no_fetch", rd_txn - f0, 0);
      chk("buf_hit_resp_cycle", rel, 1);
    end
`endif

    // Random traffic over 16 lines
    for (int i = 0; i < 150; i++) begin
      bit wr;
      bit rd;
      logic [1:0]  be;
      logic [15:0] a;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      be = 2'($urandom_range(0, 3));
      a  = {8'h00, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0};
      req(rd, wr, be, a, 16'($urandom), rel);
    end

    for (int l = 0; l < 16; l++) begin
      for (int w = 0; w < 8; w++) ln[16*w +: 16] = ref_words[l*8 + w];
      chk("final_line", pmem_arr[l], ln);
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the LC-3b datapath. It accepts 16-bit CPU word/byte requests carrying a 2-bit byte-enable (`2'b01` low byte, `2'b10` high byte, `2'b11` word) and services them against a 128-bit line-oriented physical memory port. Reads return the addressed word from the fetched line. Writes perform a fetch-merge-writeback so that only the enabled bytes change.

## Interface
- No parameters; line = 128 bits (8 words), fixed.
- `clk` in 1 — sole clock.
- `reset` in 1 — asynchronous, active-high.
- `mem_read` in 1 — CPU read request; held until `mem_resp`.
- `mem_write` in 1 — CPU write request; held until `mem_resp`.
- `mem_byte_enable` in 2 (`lc3b_sel`) — byte lanes to write; ignored on reads.
- `mem_address` in 16 — byte address; bits [3:1] select the word, bits [15:4] select the line.
- `mem_wdata` in 16 — write data, already lane-positioned.
- `mem_rdata` out 16 — read word; valid while `mem_resp`=1.
- `mem_resp` out 1 — single-cycle completion pulse.
- `pmem_read` out 1 — line fetch strobe; held until `pmem_resp`.
- `pmem_write` out 1 — line writeback strobe; held until `pmem_resp`.
- `pmem_address` out 16 — `{mem_address[15:4], 4'h0}`.
- `pmem_wdata` out 128 — merged line.
- `pmem_rdata` in 128 — fetched line; sampled when `pmem_resp`=1.
- `pmem_resp` in 1 — physical memory completion.

## Operation
- States: IDLE, FETCH, WRITE, RESP.
- IDLE:
  - On `mem_write`, go to FETCH.
  - Else on `mem_read`, go to FETCH.
  - `mem_write` wins if both are high; the request is treated as a write.
- FETCH:
  - Assert `pmem_read`.
  - On `pmem_resp`, capture `pmem_rdata` into the line register.
  - Next state: WRITE for a write with byte-enable ≠ `00`; otherwise RESP.
- Merge, for word index w = addr[3:1]:
  - Bits [16w+7:16w] take `mem_wdata[7:0]` if enable[0].
  - Bits [16w+15:16w+8] take `mem_wdata[15:8]` if enable[1].
  - All other bits are unchanged.
  - The merged line is registered on the FETCH→WRITE edge.
- WRITE: assert `pmem_write` with the merged line; on `pmem_resp`, go to RESP.
- RESP:
  - Pulse `mem_resp` for one cycle.
  - `mem_rdata` = line[16w+15:16w]; on writes it is the merged word.
  - Go to IDLE.
- A write with byte-enable `00` fetches, performs no writeback, and responds.
- Reset values:
  - State IDLE.
  - `mem_resp`, `pmem_read`, `pmem_write` = 0.
  - `mem_rdata` = 0, `pmem_wdata` = 0.
  - Line register cleared.
- Reset mid-operation forces IDLE and drops pmem strobes asynchronously; the in-flight request is abandoned with no `mem_resp`.
- `mem_address`, `mem_wdata` and `mem_byte_enable` must stay stable from request until `mem_resp`. The block re-samples them each cycle and does not latch them.

## Timing
- Request first seen high at edge 0.
- FETCH is entered and `pmem_read` is high in cycle 1.
- If `pmem_resp` is high in cycle k, then:
  - Read: `mem_resp` is high in cycle k+1.
  - Write: `pmem_write` is high from cycle k+1. If the write `pmem_resp` arrives in cycle j, `mem_resp` is high in cycle j+1.
- After RESP there is at least one IDLE cycle before the next request is accepted. The CPU deasserts its request in the cycle after `mem_resp`.
- `pmem_resp` outside FETCH/WRITE is ignored.

## Configuration
- `MEM_LINE_BUF_EN` defined:
  - Keeps a one-line buffer (valid bit, 12-bit tag, 128-bit data).
  - Read hit in IDLE goes directly to RESP, so `mem_resp` is high in cycle 1.
  - Write hit skips FETCH and goes to WRITE using the buffered line.
  - Every completed fetch or writeback updates the buffer (write-through).
  - Reset clears valid.
- `MEM_LINE_BUF_EN` undefined: every request fetches; no buffer storage is built.

## Structure
- Shared package `lc3b_types` holds:
  - `lc3b_word`, `lc3b_sel` and `lc3b_line` (`logic [127:0]`).
  - The state enum `mem_resp_state_t`.
- Sub-module `line_byte_merge`: combinational line merge of (line, word index, byte-enable, wdata) → line. It is reused by the cache.
- The FSM and datapath live in `mem_line_responder`.

## Test plan
- Read at `16'h0036`, with `pmem_rdata` word 3 = `16'hBEEF` and `pmem_resp` at cycle 3 → `pmem_address`=`16'h0030`, `mem_rdata`=`16'hBEEF`, `mem_resp` high in cycle 4 only.
- Byte write, enable `01`, addr `16'h0010`, wdata `16'h00AA`, over a fetched line of all `16'h1234` → `pmem_wdata` word 0 = `16'h12AA`, words 1–7 unchanged, one `pmem_write` transaction.
- Byte write, enable `10`, addr `16'h001E`, wdata `16'h5500` → word 7 = `16'h5534`; `mem_resp` follows the write `pmem_resp` by one cycle.
- Write with enable `00` → exactly one `pmem_read`, no `pmem_write`, `mem_resp` pulses once.
- `reset` asserted while in WRITE → `pmem_write` low in the same cycle, no `mem_resp`. A subsequent read completes normally.
- `MEM_LINE_BUF_EN`: two reads to `16'h0040` then `16'h0042` → one fetch total, second `mem_resp` in cycle 1 after request.
